multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32 datapath.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw and beq.
- Drives the mux selects, write strobes and the 2-bit ALUOp consumed by the ALU control decoder.
- Handles wait-states on a shared instruction/data memory and latches a fault on illegal opcodes or memory timeouts.

Parameters:
- BUS_TIMEOUT, 16: maximum cycles spent in one memory wait state before faulting; legal range 2..256.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  7  instruction[6:0] from the instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register and OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = Imm, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B
- Fault  out  1  sticky fault indicator
- State  out  4  current state, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXECR=7, ALUWB=8, BEQ=9, FAULT=10.
- Outputs are Moore-decoded from State. Exceptions: strobes marked "&MemReady" or "&Zero" are gated combinationally by that input.
- Any output not listed for a state is 0.
- Reset (rst_n low, asynchronous): State=IDLE; wait counter=0; every output 0. Deassertion is sampled at the next rising clk edge.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH:
  - Drives AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - MemReady=1 -> DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut captures the branch target.
  - ImmSrc: sw -> 01, beq -> 10, all other opcodes -> 00.
  - Next state by Opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 (R-type) -> EXECR
    - 1100011 (beq) -> BEQ
    - any other opcode -> FAULT
- MEMADR:
  - Drives ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - ImmSrc=01 for sw, 00 for lw.
  - Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: drives AdrSrc=1, MemRead=1. MemReady=1 -> MEMWB.
- MEMWB: drives ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWR: drives AdrSrc=1, MemWrite=1. MemReady=1 -> FETCH.
- EXECR: drives ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: drives ResultSrc=00, RegWrite=1. Next state FETCH.
- BEQ:
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite=Zero.
  - Next state FETCH.
- FAULT: all strobes 0, Fault=1. Absorbing state; only rst_n exits.
- Opcode is sampled in DECODE and MEMADR only. It must be stable while IRWrite=0.
- Wait timer (applies in FETCH, MEMRD, MEMWR):
  - Counter clears on every state change.
  - Counter increments each cycle the FSM remains in the wait state with MemReady=0.
  - If the counter equals BUS_TIMEOUT-1 and MemReady=0, next state is FAULT.
  - MemReady=1 in that same cycle wins and normal progress occurs.
- Latency with zero wait-states, FETCH to the next FETCH: lw 5, sw 4, R-type 4, beq 3 cycles. Each wait cycle adds 1.
- Reset mid-operation aborts immediately. No partial write strobe may be emitted after rst_n falls.
- MemRead and MemWrite are never high together. RegWrite and PCWrite are never high together.

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit)
  - opcode constants: OP_LW, OP_SW, OP_R, OP_BEQ
  - ALUOp codes
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc select codes
- One sub-module, mem_wait_timer:
  - Counter of width clog2(BUS_TIMEOUT).
  - Inputs: clear, count enable. Output: expired.

Test Plan:
- Reset then release, MemReady=1 -> State 0,1,2; IRWrite=PCWrite=1 in FETCH; all outputs 0 while rst_n=0.
- R-type (Opcode=0110011), MemReady=1 -> states 1,2,7,8,1; ALUOp=10 in EXECR; RegWrite=1 only in ALUWB; 4 cycles.
- lw with MemReady low 2 cycles in MEMRD -> MEMRD held 3 cycles, MEMWB ResultSrc=01 RegWrite=1; total 7 cycles.
- beq with Zero=1 then Zero=0 -> PCWrite=1 in BEQ only when Zero=1; ALUOp=01, ImmSrc=10 in DECODE.
- Opcode=0010011 -> FAULT after DECODE, Fault=1 held 20 cycles, cleared only by rst_n.
- FETCH with MemReady=0 for BUS_TIMEOUT cycles -> FAULT. Repeat with MemReady=1 on cycle BUS_TIMEOUT -> DECODE, no fault. Assert rst_n=0 mid-MEMWR -> MemWrite drops immediately, State=0.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and select codes for the multicycle RV32 control FSM
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_FAULT  = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // States that wait on the shared memory and are guarded by the bus timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags the last allowed one
module mem_wait_timer #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BUS_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multicycle RV32 datapath
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Fault,
  output logic [3:0] State
);

  state_e state_q, state_d;
  logic   wait_st, expired;

  assign wait_st = is_wait_state(state_q);

  mem_wait_timer #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_d != state_q),
    .count_i  (wait_st && !MemReady),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    ImmSrc    = IMM_I;
    Fault     = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm so BEQ can load the branch target.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (Opcode == OP_SW)  ? IMM_S :
                  (Opcode == OP_BEQ) ? IMM_B : IMM_I;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (Opcode == OP_SW) ? IMM_S : IMM_I;
        state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_SUB;
        PCWrite = Zero;
        state_d = S_FETCH;
      end
      S_FAULT: Fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    // A completing access in the last allowed wait cycle still wins.
    if (wait_st && !MemReady && expired) state_d = S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] State;
  logic [16:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  // Vector order: PCWrite AdrSrc MemRead MemWrite IRWrite RegWrite | ResultSrc | ALUSrcA | ALUSrcB | ALUOp | ImmSrc | Fault
  localparam logic [16:0] V_ZERO      = 17'd0;
  localparam logic [16:0] V_FETCH_RDY = {6'b101010, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_FETCH_WT  = {6'b001000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_DEC_I     = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_DEC_S     = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [16:0] V_DEC_B     = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] V_MADR_L    = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_MADR_S    = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 1'b0};
  localparam logic [16:0] V_MEMRD     = {6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_MEMWB     = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_MEMWR     = {6'b010100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_EXECR     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] V_ALUWB     = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] V_BEQ_T     = {6'b100000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] V_BEQ_N     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [16:0] V_FAULT     = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEMADR = 4'd3,
                         ST_MEMRD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWR = 4'd6, ST_EXECR = 4'd7,
                         ST_ALUWB = 4'd8, ST_BEQ = 4'd9, ST_FAULT = 4'd10;

  localparam logic [6:0] C_LW = 7'b0000011, C_SW = 7'b0100011, C_R = 7'b0110011,
                         C_BEQ = 7'b1100011, C_ADDI = 7'b0010011;

  multicycle_controller #(.BUS_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Fault};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check state and outputs mid-cycle, then step past the next edge.
  task automatic cyc(input string tag, input logic mr, input logic z,
                     input logic [3:0] st, input logic [16:0] v);
    MemReady = mr;
    Zero     = z;
    #1;
    chk({tag, "_state"}, 32'(State), 32'(st));
    chk({tag, "_out"}, 32'(obs), 32'(v));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(State), 32'(ST_IDLE));
    chk("rst_out", 32'(obs), 32'(V_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc("idle", 1'b1, 1'b0, ST_IDLE, V_ZERO);
  endtask

  initial begin
    rst_n    = 1'b0;
    Opcode   = C_R;
    Zero     = 1'b0;
    MemReady = 1'b1;
    #3;
    chk("reset_state", 32'(State), 32'(ST_IDLE));
    chk("reset_out", 32'(obs), 32'(V_ZERO));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_state", 32'(State), 32'(ST_IDLE));
    chk("reset_hold_out", 32'(obs), 32'(V_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc("idle", 1'b1, 1'b0, ST_IDLE, V_ZERO);

    // R-type, no wait states
    Opcode = C_R;
    cyc("r_fetch", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("r_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_I);
    cyc("r_exec", 1'b1, 1'b0, ST_EXECR, V_EXECR);
    cyc("r_wb", 1'b1, 1'b0, ST_ALUWB, V_ALUWB);

    // lw with two wait cycles in MEMRD
    Opcode = C_LW;
    cyc("lw_fetch", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("lw_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_I);
    cyc("lw_adr", 1'b1, 1'b0, ST_MEMADR, V_MADR_L);
    cyc("lw_rd0", 1'b0, 1'b0, ST_MEMRD, V_MEMRD);
    cyc("lw_rd1", 1'b0, 1'b0, ST_MEMRD, V_MEMRD);
    cyc("lw_rd2", 1'b1, 1'b0, ST_MEMRD, V_MEMRD);
    cyc("lw_wb", 1'b1, 1'b0, ST_MEMWB, V_MEMWB);

    // sw, no wait states
    Opcode = C_SW;
    cyc("sw_fetch", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("sw_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_S);
    cyc("sw_adr", 1'b1, 1'b0, ST_MEMADR, V_MADR_S);
    cyc("sw_wr", 1'b1, 1'b0, ST_MEMWR, V_MEMWR);

    // beq taken then not taken
    Opcode = C_BEQ;
    cyc("beq1_fetch", 1'b1, 1'b1, ST_FETCH, V_FETCH_RDY);
    cyc("beq1_dec", 1'b1, 1'b1, ST_DECODE, V_DEC_B);
    cyc("beq1_exec", 1'b1, 1'b1, ST_BEQ, V_BEQ_T);
    cyc("beq0_fetch", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("beq0_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_B);
    cyc("beq0_exec", 1'b1, 1'b0, ST_BEQ, V_BEQ_N);

    // FETCH stalls 15 cycles; ready arrives in the last allowed cycle
    Opcode = C_R;
    for (int i = 0; i < 15; i++) cyc("fetch_wait", 1'b0, 1'b0, ST_FETCH, V_FETCH_WT);
    cyc("fetch_last_rdy", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("late_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_I);
    cyc("late_exec", 1'b1, 1'b0, ST_EXECR, V_EXECR);
    cyc("late_wb", 1'b1, 1'b0, ST_ALUWB, V_ALUWB);

    // FETCH stalls the full timeout -> FAULT
    for (int i = 0; i < 16; i++) cyc("fetch_to", 1'b0, 1'b0, ST_FETCH, V_FETCH_WT);
    cyc("to_fault", 1'b1, 1'b0, ST_FAULT, V_FAULT);
    cyc("to_fault_hold", 1'b1, 1'b0, ST_FAULT, V_FAULT);
    do_reset();

    // reset asserted in the middle of a stalled MEMWR
    Opcode = C_SW;
    cyc("mwr_fetch", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("mwr_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_S);
    cyc("mwr_adr", 1'b1, 1'b0, ST_MEMADR, V_MADR_S);
    MemReady = 1'b0;
    #1;
    chk("mwr_pre_state", 32'(State), 32'(ST_MEMWR));
    chk("mwr_pre_out", 32'(obs), 32'(V_MEMWR));
    #1;
    do_reset();

    // illegal opcode -> FAULT, held until reset
    Opcode = C_ADDI;
    cyc("ill_fetch", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("ill_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_I);
    for (int i = 0; i < 20; i++) cyc("ill_fault", 1'(i % 2), 1'(i % 3 == 0), ST_FAULT, V_FAULT);
    do_reset();
    Opcode = C_R;
    cyc("post_fetch", 1'b1, 1'b0, ST_FETCH, V_FETCH_RDY);
    cyc("post_dec", 1'b1, 1'b0, ST_DECODE, V_DEC_I);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
